mpc_zrl_encoder: RTL and testbench
==================================

Name: mpc_zrl_encoder

Overview:
- Sits directly downstream of the transformer stage, which delivers a 256-bit bit-plane-scanned block.
- Splits the block into 32 byte symbols and run-length encodes zero symbols.
- Sends nonzero symbols as literals.
- Packs the variable-length tokens into 32-bit words with a valid/ready stream.
- Output feeds the compressed-line buffer.

Parameters:
- SYM_W, 8: symbol width in bits; fixed by the transformer output layout.
- NUM_SYM, 32: symbols per block.
- OUT_W, 32: output word width.
- ACC_W, 64: packer accumulator width.

Ports:
- clk  in  1  clock; all state on the rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  input block valid
- ready_o  out  1  encoder can accept a block
- data_i  in  256  scanned block from the transformer
- word_o  out  32  packed code word, first bit at MSB
- word_valid_o  out  1  word_o valid
- word_ready_i  in  1  consumer accepts word
- word_last_o  out  1  final word of the block
- len_o  out  9  total code length in bits, valid with word_last_o (only with MPC_ZRL_LEN_EN)

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, ready_o=1.
  - word_valid_o=0, word_last_o=0, word_o=0, len_o=0.
  - Accumulator, fill, symbol index and run counter all cleared.
  - Reset mid-block discards the block; no partial words are emitted afterwards.
- Symbol k (0..31) = data_i[255-8k -: 8], processed in ascending k.
- Tokens, appended MSB-first:
  - Zero run of length r (1..32): '0' followed by 5-bit (r-1); 6 bits.
  - Nonzero symbol s: '1' followed by s[7:0]; 9 bits.
- FSM states:
  - IDLE: ready_o=1. On valid_i&&ready_o, latch data_i, clear counters, go to ENC. ready_o=0 in all other states.
  - ENC: consumes at most one symbol per cycle.
    - Zero symbol: run counter +1, no token.
    - Nonzero symbol with run>0: the run token and the literal are appended in the same cycle (15 bits), and run is cleared.
    - Nonzero symbol with run=0: the literal only.
    - After symbol 31, go to FLUSH.
  - FLUSH: append any pending run token. Emit remaining full words, then one zero-padded final word if fill>0. Go to IDLE after the last word is accepted.
- Stall rule: let fill_after = fill - (word emitted this cycle ? 32 : 0). ENC consumes a symbol only if fill_after <= 49. Otherwise it holds the symbol index and run counter.
- Output handshake:
  - word_valid_o asserts whenever fill>=32, or in FLUSH when fill>0.
  - word_o is the top 32 bits of the accumulator.
  - word_o, word_valid_o and word_last_o are held stable until word_ready_i.
  - A transfer occurs on word_valid_o&&word_ready_i.
  - word_last_o=1 only on the final word of a block.
- Latency:
  - First word is valid no earlier than 4 cycles after acceptance with word_ready_i held high.
  - The next block is accepted the cycle after the last word transfers. There is no overlap between blocks.
- Limits:
  - Maximum code length is 288 bits (9 words).
  - Minimum is 6 bits (1 word).
  - len_o counts only token bits, not padding.

Optional Feature:
- MPC_ZRL_LEN_EN defined: the len_o port exists, accumulates token bits per block, and is valid while word_last_o=1.
- Undefined: the len_o port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mpc_pkg holds:
  - ZRL_RUN_TAG=1'b0 and ZRL_LIT_TAG=1'b1.
  - ZRL_RUN_LEN=6 and ZRL_LIT_LEN=9.
  - MAX_CODE_BITS=288.
  - The FSM state enum (IDLE, ENC, FLUSH).
- One sub-module, mpc_bit_packer:
  - Inputs: up to 15 bits plus a length.
  - Owns the 64-bit accumulator, fill count and word handshake.
  - Reports fill to the FSM for the stall rule.

Test Plan:
- All-zero block, word_ready_i=1 → one word 0x7C000000, word_last_o=1, len_o=6.
- Symbol0=0xA5, others 0 → one word 0xD2BC0000, last=1, len_o=15.
- All symbols 0xFF → nine words 0xFFFFFFFF, last on the 9th, len_o=288. The encoder stalls (no symbol advance) while fill_after>49.
- Alternating 0x00/0x01 symbols, with word_ready_i toggling every 3 cycles → word stream matches the golden model, and words are held stable during backpressure.
- Assert rst_n low mid-ENC, then send an all-zero block → no stale words; only 0x7C000000 is emitted.
- Back-to-back valid_i → the second block is accepted exactly one cycle after the first block's last word transfers, with ready_o=0 throughout.

Source files
------------

// File: rtl/mpc_zrl_encoder_pkg.sv
// Shared constants, token formats and FSM state type for the zero-run-length
// encoder and its bit packer.
package mpc_pkg;

  localparam int SYM_W   = 8;
  localparam int NUM_SYM = 32;
  localparam int OUT_W   = 32;
  localparam int ACC_W   = 64;
  localparam int BLK_W   = SYM_W * NUM_SYM;

  localparam int IDX_W     = 5;   // symbol index 0..31
  localparam int RUN_W     = 6;   // run counter 0..32
  localparam int FILL_W    = 7;   // accumulator fill 0..64
  localparam int TOK_W     = 15;  // widest append: run token + literal
  localparam int TOK_LEN_W = 4;   // append length 0..15
  localparam int LEN_W     = 9;   // code length 0..288

  localparam logic ZRL_RUN_TAG = 1'b0;
  localparam logic ZRL_LIT_TAG = 1'b1;
  localparam int   ZRL_RUN_LEN = 6;
  localparam int   ZRL_LIT_LEN = 9;
  localparam int   MAX_CODE_BITS = 288;

  // Fill thresholds, typed to the fill counter width.
  localparam logic [FILL_W-1:0] FILL_WORD  = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] STALL_FILL = FILL_W'(ACC_W - TOK_W);
  localparam logic [FILL_W-1:0] RUN_FILL   = FILL_W'(ACC_W - ZRL_RUN_LEN);

  localparam logic [TOK_LEN_W-1:0] LEN_RUN  = TOK_LEN_W'(ZRL_RUN_LEN);
  localparam logic [TOK_LEN_W-1:0] LEN_LIT  = TOK_LEN_W'(ZRL_LIT_LEN);
  localparam logic [TOK_LEN_W-1:0] LEN_BOTH = TOK_LEN_W'(ZRL_RUN_LEN + ZRL_LIT_LEN);

  typedef enum logic [1:0] {IDLE, ENC, FLUSH} zrl_state_e;

  // Run token for a run of 'run' zeros (1..32): tag, then run-1 in 5 bits.
  function automatic logic [ZRL_RUN_LEN-1:0] run_token(input logic [RUN_W-1:0] run);
    return {ZRL_RUN_TAG, (ZRL_RUN_LEN-1)'(run - RUN_W'(1))};
  endfunction

endpackage

// File: rtl/mpc_zrl_encoder_if.sv
// Block-in / word-out stream bundle of the zero-run-length encoder.
// len_o exists only when MPC_ZRL_LEN_EN is defined.
interface mpc_zrl_encoder_if;
  import mpc_pkg::*;

  logic             valid_i;
  logic             ready_o;
  logic [BLK_W-1:0] data_i;
  logic [OUT_W-1:0] word_o;
  logic             word_valid_o;
  logic             word_ready_i;
  logic             word_last_o;
`ifdef MPC_ZRL_LEN_EN
  logic [LEN_W-1:0] len_o;

  modport slave  (input  valid_i, data_i, word_ready_i,
                  output ready_o, word_o, word_valid_o, word_last_o, len_o);
  modport master (output valid_i, data_i, word_ready_i,
                  input  ready_o, word_o, word_valid_o, word_last_o, len_o);
`else
  modport slave  (input  valid_i, data_i, word_ready_i,
                  output ready_o, word_o, word_valid_o, word_last_o);
  modport master (output valid_i, data_i, word_ready_i,
                  input  ready_o, word_o, word_valid_o, word_last_o);
`endif
endinterface

// File: rtl/mpc_bit_packer.sv
// Packs MSB-first tokens of up to 15 bits into a 64-bit accumulator and
// presents the top 32 bits as a valid/ready word stream.
module mpc_bit_packer
  import mpc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,      // start of a new block
  input  logic                 app_en_i,
  input  logic [TOK_W-1:0]     app_bits_i,   // left-aligned token bits
  input  logic [TOK_LEN_W-1:0] app_len_i,
  input  logic                 final_i,      // no more tokens: pad the tail
  output logic [FILL_W-1:0]    fill_after_o, // fill once this cycle's word leaves
  output logic                 xfer_o,
  output logic [OUT_W-1:0]     word_o,
  output logic                 word_valid_o,
  output logic                 word_last_o,
  input  logic                 word_ready_i
);
  logic [ACC_W-1:0]  acc_q,  acc_d, acc_base;
  logic [FILL_W-1:0] fill_q, fill_d, fill_base;
  logic [ACC_W-1:0]  tok_pos;

  // Bits below the fill point are always zero, so the final word is padded.
  assign word_o       = acc_q[ACC_W-1 -: OUT_W];
  assign word_valid_o = (fill_q >= FILL_WORD) || (final_i && fill_q != '0);
  assign word_last_o  = final_i && fill_q != '0 && fill_q <= FILL_WORD;
  assign xfer_o       = word_valid_o && word_ready_i;
  assign fill_after_o = fill_base;

  // Drop the transferred word, then drop the new token in just below the fill.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    acc_base  = acc_q;
    fill_base = fill_q;
    if (xfer_o) begin
      acc_base  = acc_q << OUT_W;
      fill_base = (fill_q > FILL_WORD) ? fill_q - FILL_WORD : '0;
    end
    tok_pos = {app_bits_i, {(ACC_W-TOK_W){1'b0}}} >> fill_base;
    acc_d   = acc_base;
    fill_d  = fill_base;
    if (clear_i) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (app_en_i) begin
      acc_d  = acc_base | tok_pos;
      fill_d = fill_base + {{(FILL_W-TOK_LEN_W){1'b0}}, app_len_i};
    end
  end

  // Accumulator and fill registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/mpc_zrl_encoder.sv
// Zero-run-length encoder: 32 byte symbols per 256-bit block, zero runs as
// 6-bit tokens, nonzero symbols as 9-bit literals, packed into 32-bit words.
// Optional macro MPC_ZRL_LEN_EN adds the per-block code length output len_o.
module mpc_zrl_encoder
  import mpc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  mpc_zrl_encoder_if.slave bus
);
  zrl_state_e             state_q;
  logic                   ready_q;
  logic [BLK_W-1:0]       data_q;
  logic [IDX_W-1:0]       idx_q;
  logic [RUN_W-1:0]       run_q;

  logic [SYM_W-1:0]       sym;
  logic                   sym_zero, accept, consume, run_pending, run_fits, final_phase;
  logic                   app_en, xfer;
  logic [TOK_W-1:0]       app_bits;
  logic [TOK_LEN_W-1:0]   app_len;
  logic [FILL_W-1:0]      fill_after;
  logic [ZRL_RUN_LEN-1:0] run_tok;
  logic [ZRL_LIT_LEN-1:0] lit_tok;

  // The current symbol is always the top byte of the shifting block register.
  assign sym         = data_q[BLK_W-1 -: SYM_W];
  assign sym_zero    = (sym == '0);
  assign run_tok     = run_token(run_q);
  assign lit_tok     = {ZRL_LIT_TAG, sym};
  assign accept      = (state_q == IDLE) && bus.valid_i && ready_q;
  assign consume     = (state_q == ENC) && (fill_after <= STALL_FILL);
  assign run_pending = (run_q != '0);
  assign run_fits    = (fill_after <= RUN_FILL);
  assign final_phase = (state_q == FLUSH) && !run_pending;
  assign bus.ready_o = ready_q;

  // Token selection for this cycle: run+literal, literal, or the trailing run.
  always_comb begin
    app_en   = 1'b0;
    app_bits = '0;
    app_len  = '0;
    if (consume && !sym_zero) begin
      app_en = 1'b1;
      if (run_pending) begin
        app_bits = {run_tok, lit_tok};
        app_len  = LEN_BOTH;
      end else begin
        app_bits = {lit_tok, {ZRL_RUN_LEN{1'b0}}};
        app_len  = LEN_LIT;
      end
    end else if (state_q == FLUSH && run_pending && run_fits) begin
      app_en   = 1'b1;
      app_bits = {run_tok, {ZRL_LIT_LEN{1'b0}}};
      app_len  = LEN_RUN;
    end
  end

  // Block FSM: accept, walk the symbols, flush the tail, then reopen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      data_q  <= '0;
      idx_q   <= '0;
      run_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q  <= bus.data_i;
            idx_q   <= '0;
            run_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ENC;
          end
        end
        ENC: begin
          if (consume) begin
            data_q <= data_q << SYM_W;
            idx_q  <= idx_q + 1'b1;
            run_q  <= sym_zero ? run_q + 1'b1 : '0;
            if (idx_q == IDX_W'(NUM_SYM - 1)) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (run_pending) begin
            if (run_fits) run_q <= '0;
          end else if (xfer && bus.word_last_o) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MPC_ZRL_LEN_EN
  logic [LEN_W-1:0] len_q;

  // Token bit count for the current block; stable by the time the last word shows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      len_q <= '0;
    else if (accept) len_q <= '0;
    else if (app_en) len_q <= len_q + LEN_W'(app_len);
  end

  assign bus.len_o = len_q;
`endif

  mpc_bit_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (accept),
    .app_en_i     (app_en),
    .app_bits_i   (app_bits),
    .app_len_i    (app_len),
    .final_i      (final_phase),
    .fill_after_o (fill_after),
    .xfer_o       (xfer),
    .word_o       (bus.word_o),
    .word_valid_o (bus.word_valid_o),
    .word_last_o  (bus.word_last_o),
    .word_ready_i (bus.word_ready_i)
  );

endmodule

// File: tb/tb_mpc_zrl_encoder.sv
// Self-checking bench for mpc_zrl_encoder: table of directed blocks plus
// backpressure, mid-block reset and back-to-back sequences.
`timescale 1ns/1ps
module tb_mpc_zrl_encoder;
  import mpc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mpc_zrl_encoder_if bus();

  mpc_zrl_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] got_w [12];
  int          got_n;
  logic [8:0]  got_len;

  typedef struct {
    logic [255:0] data;
    int           nwords;
    logic [31:0]  w0;
    logic [31:0]  wl;
    int           len;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder working straight from the token definitions.
  function automatic void model(input logic [255:0] d, output logic [31:0] w [9],
                                output int nw, output int nb);
    logic [287:0] s;
    logic [7:0]   sym;
    logic [4:0]   rl;
    int           run;
    s = '0; nb = 0; run = 0;
    for (int k = 0; k < 33; k++) begin
      sym = (k < 32) ? d[255-8*k -: 8] : 8'h01;
      if (k < 32 && sym == 8'h00) begin
        run++;
      end else begin
        if (run > 0) begin
          rl = 5'(run - 1);
          s[287-nb] = 1'b0; nb++;
          for (int b = 4; b >= 0; b--) begin s[287-nb] = rl[b]; nb++; end
          run = 0;
        end
        if (k < 32) begin
          s[287-nb] = 1'b1; nb++;
          for (int b = 7; b >= 0; b--) begin s[287-nb] = sym[b]; nb++; end
        end
      end
    end
    nw = (nb + 31) / 32;
    for (int i = 0; i < 9; i++) w[i] = s[287-32*i -: 32];
  endfunction

  // Offer a block at the current negedge and wait for it to be taken.
  task automatic send_block(input logic [255:0] d, input string tag);
    int t = 0;
    bus.data_i  = d;
    bus.valid_i = 1'b1;
    while (!bus.ready_o && t < 1000) begin @(negedge clk); t++; end
    check({tag, "_accept_timeout"}, 32'(t < 1000), 32'd1);
    @(negedge clk);
    bus.valid_i = 1'b0;
  endtask

  // Drain one block's words; bp toggles word_ready_i every 3 cycles.
  task automatic collect(input bit bp, input string tag);
    int          cyc = 0;
    bit          done = 0, held = 0, stable_ok = 1, rdy_ok = 1;
    logic [31:0] hw;
    logic        hl;
    got_n = 0; got_len = '0; hw = '0; hl = 1'b0;
    while (!done && cyc < 3000) begin
      bus.word_ready_i = bp ? (((cyc / 3) % 2) == 1) : 1'b1;
      if (bus.ready_o) rdy_ok = 0;
      if (bus.word_valid_o) begin
        if (held && (bus.word_o !== hw || bus.word_last_o !== hl)) stable_ok = 0;
        if (bus.word_ready_i) begin
          if (got_n < 12) got_w[got_n] = bus.word_o;
          got_n++;
          held = 0;
          if (bus.word_last_o) begin
            done = 1;
`ifdef MPC_ZRL_LEN_EN
            got_len = bus.len_o;
`endif
          end
        end else begin
          held = 1; hw = bus.word_o; hl = bus.word_last_o;
        end
      end else if (held) begin
        stable_ok = 0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.word_ready_i = 1'b1;
    check({tag, "_last_seen"}, 32'(done), 32'd1);
    check({tag, "_held_stable"}, 32'(stable_ok), 32'd1);
    check({tag, "_ready_low_busy"}, 32'(rdy_ok), 32'd1);
  endtask

  // Compare the collected stream against the reference encoder.
  task automatic check_stream(input logic [255:0] d, input string tag);
    logic [31:0] mw [9];
    int          mn, mb;
    model(d, mw, mn, mb);
    check({tag, "_nwords_model"}, 32'(got_n), 32'(mn));
    for (int i = 0; i < mn && i < got_n && i < 12; i++)
      check($sformatf("%s_word%0d", tag, i), got_w[i], mw[i]);
`ifdef MPC_ZRL_LEN_EN
    check({tag, "_len_model"}, 32'(got_len), 32'(mb));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ok;
    bus.valid_i = 1'b0;
    bus.data_i = '0;
    bus.word_ready_i = 1'b1;

    vecs[0] = '{data: '0,                       nwords: 1, w0: 32'h7C00_0000, wl: 32'h7C00_0000, len: 6};
    vecs[1] = '{data: {8'hA5, 248'h0},          nwords: 1, w0: 32'hD2BC_0000, wl: 32'hD2BC_0000, len: 15};
    vecs[2] = '{data: {256{1'b1}},              nwords: 9, w0: 32'hFFFF_FFFF, wl: 32'hFFFF_FFFF, len: 288};
    vecs[3] = '{data: {248'h0, 8'h80},          nwords: 1, w0: 32'h7B00_0000, wl: 32'h7B00_0000, len: 15};
    vecs[4] = '{data: {8'h01, 248'h0},          nwords: 1, w0: 32'h80BC_0000, wl: 32'h80BC_0000, len: 15};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.ready_o), 32'd1);
    check("rst_word_valid", 32'(bus.word_valid_o), 32'd0);
    check("rst_word_last", 32'(bus.word_last_o), 32'd0);
    check("rst_word", bus.word_o, 32'h0);
`ifdef MPC_ZRL_LEN_EN
    check("rst_len", 32'(bus.len_o), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      send_block(vecs[v].data, tag);
      collect(1'b0, tag);
      check({tag, "_nwords"}, 32'(got_n), 32'(vecs[v].nwords));
      check({tag, "_w0"}, got_w[0], vecs[v].w0);
      if (got_n >= 1 && got_n <= 12) check({tag, "_wlast"}, got_w[got_n-1], vecs[v].wl);
`ifdef MPC_ZRL_LEN_EN
      check({tag, "_len"}, 32'(got_len), 32'(vecs[v].len));
`endif
      check_stream(vecs[v].data, tag);
    end

    // Alternating 00/01 symbols under backpressure.
    send_block({16{16'h0001}}, "alt");
    collect(1'b1, "alt");
    check("alt_nwords", 32'(got_n), 32'd8);
    check("alt_w0", got_w[0], 32'h0202_0404);
    check("alt_w7", got_w[7], 32'h8101_0000);
`ifdef MPC_ZRL_LEN_EN
    check("alt_len", 32'(got_len), 32'd240);
`endif
    check_stream({16{16'h0001}}, "alt");

    // Reset in the middle of encoding a block.
    bus.word_ready_i = 1'b0;
    send_block({256{1'b1}}, "rst_mid");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(bus.ready_o), 32'd1);
    check("rst_mid_valid", 32'(bus.word_valid_o), 32'd0);
    check("rst_mid_word", bus.word_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.word_ready_i = 1'b1;
    ok = 1;
    repeat (4) begin
      @(negedge clk);
      if (bus.word_valid_o) ok = 0;
    end
    check("rst_mid_no_stale", 32'(ok), 32'd1);
    send_block('0, "rst_after");
    collect(1'b0, "rst_after");
    check("rst_after_nwords", 32'(got_n), 32'd1);
    check("rst_after_w0", got_w[0], 32'h7C00_0000);

    // Back-to-back blocks with valid_i held high.
    bus.data_i  = {8'hA5, 248'h0};
    bus.valid_i = 1'b1;
    while (!bus.ready_o) @(negedge clk);
    @(negedge clk);
    bus.data_i = '0;
    collect(1'b0, "b2b_a");
    check("b2b_a_w0", got_w[0], 32'hD2BC_0000);
    check("b2b_ready_after_last", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    check("b2b_accepted_next", 32'(bus.ready_o), 32'd0);
    bus.valid_i = 1'b0;
    collect(1'b0, "b2b_b");
    check("b2b_b_nwords", 32'(got_n), 32'd1);
    check("b2b_b_w0", got_w[0], 32'h7C00_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
